axa_undo_stack: RTL and testbench



---
 rtl/axa_undo_stack.sv | 130 +++++++++++++
 tb/tb_axa_undo_stack.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axa_undo_stack.sv
// axa_undo_stack: circular LIFO holding old destination values for undo.
// When full, a push overwrites the oldest entry and pulses dropped.
// Peek reads any entry by depth combinationally (0 = top of stack).
// Optional build macro AXA_UNDO_CLEAR_EN adds a clear input that flushes
// the history in one cycle.
module axa_undo_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             reset,
`ifdef AXA_UNDO_CLEAR_EN
   input  logic             clear,
`endif
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   input  logic [PTR_W-1:0] peek_idx,
   output logic [WIDTH-1:0] peek_data,
   output logic             peek_valid,
   output logic [PTR_W:0]   count,
   output logic             empty,
   output logic             full,
   output logic             dropped,
   output logic             pop_err
);

   localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_tp;
   logic [PTR_W:0]   r_count;
   logic [WIDTH-1:0] r_pop_data;
   logic             r_pop_valid;
   logic             r_dropped;
   logic             r_pop_err;

   logic             w_clear;
   logic             w_empty;
   logic             w_full;
   logic [PTR_W-1:0] w_top;
   logic             w_replace;
   logic             w_wr_en;
   logic [PTR_W-1:0] w_wr_addr;
   logic [PTR_W-1:0] w_peek_ptr;

`ifdef AXA_UNDO_CLEAR_EN
   assign w_clear = clear;
`else
   assign w_clear = 1'b0;
`endif

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == C_DEPTH);
   assign w_top     = r_tp - PTR_W'(1);
   // Push and pop together on a non-empty stack swaps the top entry in place.
   assign w_replace = push && pop && !w_empty;
   assign w_wr_en   = !reset && !w_clear && push;
   assign w_wr_addr = w_replace ? w_top : r_tp;

   // Storage write: either the next free slot or the top slot on a replace.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= push_data;
      end
   end

   // Pointer, occupancy, popped value and single-cycle status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tp        <= '0;
         r_count     <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_dropped   <= 1'b0;
         r_pop_err   <= 1'b0;
      end else begin
         r_pop_valid <= 1'b0;
         r_dropped   <= 1'b0;
         r_pop_err   <= 1'b0;
         if (w_clear) begin
            r_tp    <= '0;
            r_count <= '0;
         end else if (w_replace) begin
            r_pop_data  <= r_mem[w_top];
            r_pop_valid <= 1'b1;
         end else if (pop && !w_empty) begin
            r_pop_data  <= r_mem[w_top];
            r_pop_valid <= 1'b1;
            r_tp        <= w_top;
            r_count     <= r_count - 1'b1;
         end else begin
            // Reaching here with pop set means the stack is empty.
            if (pop) begin
               r_pop_err <= 1'b1;
            end
            if (push) begin
               r_tp <= r_tp + PTR_W'(1);
               if (w_full) begin
                  r_dropped <= 1'b1;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
         end
      end
   end

   // Peek walks down from the top entry; out-of-range depths read as zero.
   always_comb begin
      w_peek_ptr = w_top - peek_idx;
      peek_valid = ({1'b0, peek_idx} < r_count);
      peek_data  = '0;
      if (peek_valid) begin
         peek_data = r_mem[w_peek_ptr];
      end
   end

   assign pop_data  = r_pop_data;
   assign pop_valid = r_pop_valid;
   assign count     = r_count;
   assign empty     = w_empty;
   assign full      = w_full;
   assign dropped   = r_dropped;
   assign pop_err   = r_pop_err;

endmodule

// File: tb/tb_axa_undo_stack.sv
// tb_axa_undo_stack: directed plan plus randomized traffic for axa_undo_stack,
// checked against a queue model (element 0 = top of stack).
// Build with AXA_UNDO_CLEAR_EN defined to also exercise the clear input.
module tb_axa_undo_stack;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int PTR_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
`ifdef AXA_UNDO_CLEAR_EN
   logic             clear = 1'b0;
`endif
   logic             push = 1'b0;
   logic [WIDTH-1:0] push_data = '0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;
   logic [PTR_W-1:0] peek_idx = '0;
   logic [WIDTH-1:0] peek_data;
   logic             peek_valid;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             dropped;
   logic             pop_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   // Reference model state
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_pop_data = '0;
   bit               m_pop_valid = 0;
   bit               m_dropped = 0;
   bit               m_pop_err = 0;

   axa_undo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef AXA_UNDO_CLEAR_EN
      .clear      (clear),
`endif
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .pop_data   (pop_data),
      .pop_valid  (pop_valid),
      .peek_idx   (peek_idx),
      .peek_data  (peek_data),
      .peek_valid (peek_valid),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .dropped    (dropped),
      .pop_err    (pop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d)", tag, got, exp, n_txn);
      end
   endtask

   // Stack semantics written directly on the queue.
   task automatic model_update(input bit rs, input bit cl, input bit pu, input bit po,
                               input logic [WIDTH-1:0] d);
      m_pop_valid = 0;
      m_dropped   = 0;
      m_pop_err   = 0;
      if (rs) begin
         m_q.delete();
         m_pop_data = '0;
      end else if (cl) begin
         m_q.delete();
      end else if (pu && po && m_q.size() > 0) begin
         m_pop_data  = m_q[0];
         m_q[0]      = d;
         m_pop_valid = 1;
      end else begin
         if (po) begin
            if (m_q.size() > 0) begin
               m_pop_data  = m_q.pop_front();
               m_pop_valid = 1;
            end else begin
               m_pop_err = 1;
            end
         end
         if (pu) begin
            if (m_q.size() == DEPTH) begin
               void'(m_q.pop_back());
               m_dropped = 1;
            end
            m_q.push_front(d);
         end
      end
   endtask

   task automatic check_peek(input int idx);
      logic [WIDTH-1:0] exp_d;
      bit exp_v;
      peek_idx = PTR_W'(idx);
      #1;
      exp_v = (idx < m_q.size());
      exp_d = exp_v ? m_q[idx] : '0;
      check("peek_valid", 32'(peek_valid), 32'(exp_v));
      check("peek_data", 32'(peek_data), 32'(exp_d));
   endtask

   task automatic check_outputs();
      check("count", 32'(count), 32'(m_q.size()));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("pop_valid", 32'(pop_valid), 32'(m_pop_valid));
      check("dropped", 32'(dropped), 32'(m_dropped));
      check("pop_err", 32'(pop_err), 32'(m_pop_err));
      check("pop_data", 32'(pop_data), 32'(m_pop_data));
      check_peek(0);
      check_peek(int'($urandom_range(0, DEPTH - 1)));
   endtask

   // One transaction: drive at negedge, model at posedge, check at next negedge.
   task automatic step(input bit rs, input bit cl, input bit pu, input bit po,
                       input logic [WIDTH-1:0] d);
      reset     = rs;
      push      = pu;
      pop       = po;
      push_data = d;
`ifdef AXA_UNDO_CLEAR_EN
      clear     = cl;
`endif
      @(posedge clk);
      model_update(rs, cl, pu, po, d);
      @(negedge clk);
      n_txn++;
      $display("txn %0d rst=%b clr=%b push=%b pop=%b data=%h -> count=%0d pop_data=%h pv=%b drop=%b perr=%b",
               n_txn, rs, cl, pu, po, d, count, pop_data, pop_valid, dropped, pop_err);
      check_outputs();
   endtask

   initial begin
      @(negedge clk);
      step(1, 0, 0, 0, '0);
      step(1, 0, 0, 0, '0);

      // Three pushes, then peek the stack in order.
      step(0, 0, 1, 0, 16'h1111);
      step(0, 0, 1, 0, 16'h2222);
      step(0, 0, 1, 0, 16'h3333);
      check("plan_count3", 32'(count), 32'd3);
      peek_idx = 4'd2; #1;
      check("plan_peek2", 32'(peek_data), 32'h1111);
      peek_idx = 4'd3; #1;
      check("plan_peek3_valid", 32'(peek_valid), 32'd0);
      check("plan_peek3_data", 32'(peek_data), 32'd0);

      // Drain, then underflow.
      step(0, 0, 0, 1, '0);
      check("plan_pop1", 32'(pop_data), 32'h3333);
      step(0, 0, 0, 1, '0);
      step(0, 0, 0, 1, '0);
      check("plan_pop3", 32'(pop_data), 32'h1111);
      step(0, 0, 0, 1, '0);
      check("plan_underflow_err", 32'(pop_err), 32'd1);
      check("plan_underflow_hold", 32'(pop_data), 32'h1111);
      step(0, 0, 0, 0, '0);

      // Overflow: 17 pushes into 16 entries.
      for (int i = 0; i < 17; i++) step(0, 0, 1, 0, WIDTH'(i));
      check("plan_dropped17", 32'(dropped), 32'd1);
      peek_idx = 4'd15; #1;
      check("plan_peek15", 32'(peek_data), 32'h0001);

      // Replace-top, then push+pop on empty.
      step(1, 0, 0, 0, '0);
      step(0, 0, 1, 0, 16'h1234);
      step(0, 0, 1, 0, 16'hBEEF);
      step(0, 0, 1, 1, 16'hCAFE);
      check("plan_replace_pop", 32'(pop_data), 32'hBEEF);
      step(1, 0, 0, 0, '0);
      step(0, 0, 1, 1, 16'h5A5A);
      check("plan_empty_pp_count", 32'(count), 32'd1);

      // Reset mid-stream with push held.
      step(0, 0, 1, 0, 16'h7777);
      step(1, 0, 1, 0, 16'h8888);
`ifdef AXA_UNDO_CLEAR_EN
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0, WIDTH'($urandom));
      step(0, 1, 1, 0, 16'h9999);
      check("plan_clear_count", 32'(count), 32'd0);
`endif

      // Randomized traffic with shifting push bias to visit empty and full.
      for (int i = 0; i < 600; i++) begin
         int pct;
         bit rs, cl, pu, po;
         case (i / 150)
            0:       pct = 70;
            1:       pct = 25;
            2:       pct = 50;
            default: pct = 90;
         endcase
         rs = ($urandom_range(0, 99) == 0);
`ifdef AXA_UNDO_CLEAR_EN
         cl = ($urandom_range(0, 39) == 0);
`else
         cl = 0;
`endif
         pu = ($urandom_range(0, 99) < pct);
         po = ($urandom_range(0, 99) < (100 - pct));
         step(rs, cl, pu, po, WIDTH'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
